instqueue_mw: RTL and testbench
===============================

Name: instqueue_mw

Overview:
- Parametrised multi-lane instruction queue between instruction fetch and the decoder(s).
- Accepts up to IN_W instructions per cycle from fetch and issues up to OUT_W instructions per cycle, in program order, as registered outputs.
- Uses an explicit occupancy counter, so all DEPTH slots are usable. It exports occupancy and flushes on any of the three redirect sources (ROB, decoder, branch predictor).

Parameters:
- DEPTH, 8: number of entries; power of two; DEPTH >= IN_W and DEPTH >= OUT_W.
- IN_W, 2: enqueue lanes per cycle.
- OUT_W, 2: dequeue lanes per cycle.
- IDW, 32: instruction width (matches `IDWidth).
- AW, 32: PC width (matches `AddressWidth).
- CIW = clog2(IN_W+1); CNW = clog2(DEPTH+1): derived localparams.

Ports:
- clk_in  in  1  clock, rising edge.
- rst_n_in  in  1  reset, asynchronous, active-low.
- rdy_in  in  1  global ready; when low, all state and outputs are frozen.
- stall_in  in  1  decoder back-pressure; no dequeue this cycle.
- if_instqueue_cnt_in  in  CIW  number of valid fetch lanes this cycle (0..IN_W), packed from lane 0.
- if_instqueue_inst_in  in  IN_W*IDW  fetch instructions; lane i at bits [i*IDW +: IDW].
- if_instqueue_pc_in  in  IN_W*AW  fetch PCs; same lane packing.
- instqueue_if_rdy_out  out  1  queue can accept a full IN_W bundle.
- rob_instqueue_rst_in  in  1  flush.
- decoder_instqueue_rst_in  in  1  flush.
- bp_instqueue_rst_in  in  1  flush.
- instqueue_decoder_en_out  out  OUT_W  per-lane valid, thermometer-coded from lane 0.
- instqueue_decoder_inst_out  out  OUT_W*IDW  issued instructions; lane 0 is oldest.
- instqueue_decoder_pc_out  out  OUT_W*AW  issued PCs.
- instqueue_count_out  out  CNW  current occupancy, registered.

Behaviour:
- State: storage arrays, head and tail pointers (log2 DEPTH bits, natural wrap), count (CNW bits).
- Reset (rst_n_in=0, asynchronous): head=tail=count=0; en_out=0; inst_out=0; pc_out=0; storage contents don't-care (need not be cleared).
- rdy_in=0: no state change; outputs hold their previous values.
- Flush (any *_rst_in=1 with rdy_in=1):
  - head=tail=count=0 and en_out=0 next edge.
  - inst_out and pc_out hold their values.
  - Overrides a same-cycle push and pop; fetch data presented that cycle is dropped.
- instqueue_if_rdy_out = (DEPTH - count) >= IN_W.
  - Combinational from registered count only.
  - Ignores a same-cycle pop (conservative).
- Push: only when rdy_out=1 and cnt_in>0.
  - Lanes 0..cnt_in-1 are written to tail, tail+1, ... (mod DEPTH).
  - tail += cnt_in.
  - If rdy_out=0, the bundle is ignored entirely; fetch must hold and re-present it.
  - cnt_in > IN_W is illegal (assertion in bench).
- Pop: when stall_in=0, pop n = min(count, OUT_W), where count is the value before this cycle's push.
  - Lane k gets entry head+k (mod DEPTH) for k<n.
  - en_out[k]=1 for k<n, 0 otherwise; head += n.
  - Lanes k>=n: data don't-care (may hold stale values).
- stall_in=1 or count=0: en_out=0 next cycle; data outputs hold.
- Latency: an instruction pushed at edge T is issuable at the earliest at edge T+1 and visible on the outputs after edge T+1. There is no fall-through bypass.
- Simultaneous push and pop: count_next = count + pushed - n. Both pointers wrap independently.
- Invariants: count <= DEPTH; count==0 implies head==tail; count==DEPTH implies head==tail.
- instqueue_count_out = count register.

Test Plan:
- Reset mid-stream: with 5 entries queued, pulse rst_n_in low between edges -> immediately en_out=0 and count_out=0; after release, rdy_out=1.
- Fill with stall_in=1, DEPTH=8, IN_W=2: push 4 bundles of cnt=2 (PCs 0x00..0x1C) -> count_out 2,4,6,8; rdy_out drops after count=8 (free 0 < 2). Then a push of cnt=2 is ignored and count stays 8.
- Drain with stall_in=0, OUT_W=2, starting from 8 entries -> en_out=2'b11 for 4 cycles with PC pairs (0x00,0x04) … (0x18,0x1C), then en_out=2'b00; count returns to 0.
- Odd occupancy: push cnt=1 (PC 0x40) then stall_in=0 -> en_out=2'b01, pc lane0=0x40.
- Wrap with concurrent push+pop: sustain cnt=2 pushes and 2-wide pops for 20 cycles -> in-order PCs, no gaps, count stable at 2; the head pointer wraps at least 4 times.
- Flush collision: with count=6, assert bp_instqueue_rst_in together with cnt_in=2 and stall_in=0 -> next cycle count=0, en_out=0, and the new bundle is dropped. With rdy_in=0 in the same setup, nothing changes.

Source files
------------

// File: rtl/instqueue_mw.sv
// Multi-lane in-order instruction queue between fetch and decode: up to IN_W pushes and OUT_W pops per cycle, registered issue (1 cycle min latency).
// Fetch sees ready only when a full IN_W bundle fits; stall_in blocks issue; rdy_in freezes everything; any redirect flushes.
module instqueue_mw #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned IN_W  = 2,
  parameter int unsigned OUT_W = 2,
  parameter int unsigned IDW   = 32,
  parameter int unsigned AW    = 32,
  localparam int unsigned CIW  = $clog2(IN_W + 1),
  localparam int unsigned CNW  = $clog2(DEPTH + 1)
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 rdy_in,
  input  logic                 stall_in,
  input  logic [CIW-1:0]       if_instqueue_cnt_in,
  input  logic [IN_W*IDW-1:0]  if_instqueue_inst_in,
  input  logic [IN_W*AW-1:0]   if_instqueue_pc_in,
  output logic                 instqueue_if_rdy_out,
  input  logic                 rob_instqueue_rst_in,
  input  logic                 decoder_instqueue_rst_in,
  input  logic                 bp_instqueue_rst_in,
  output logic [OUT_W-1:0]     instqueue_decoder_en_out,
  output logic [OUT_W*IDW-1:0] instqueue_decoder_inst_out,
  output logic [OUT_W*AW-1:0]  instqueue_decoder_pc_out,
  output logic [CNW-1:0]       instqueue_count_out
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [IDW-1:0] mem_inst [DEPTH];
  logic [AW-1:0]  mem_pc   [DEPTH];

  logic [PW-1:0]  head;
  logic [PW-1:0]  tail;
  logic [CNW-1:0] count;

  logic [OUT_W-1:0]           en_q;
  logic [OUT_W-1:0][IDW-1:0]  inst_q;
  logic [OUT_W-1:0][AW-1:0]   pc_q;

  logic [IN_W-1:0][IDW-1:0]   fetch_inst;
  logic [IN_W-1:0][AW-1:0]    fetch_pc;

  logic           flush;
  logic           can_push;
  logic [CIW-1:0] push_n;
  logic [CNW-1:0] pop_n;
  logic [CNW-1:0] count_nxt;

  assign fetch_inst = if_instqueue_inst_in;
  assign fetch_pc   = if_instqueue_pc_in;

  assign flush = rob_instqueue_rst_in | decoder_instqueue_rst_in | bp_instqueue_rst_in;

  // Ready looks only at the registered count, so a same-cycle pop never frees room early.
  assign can_push = (count <= CNW'(DEPTH - IN_W));
  assign instqueue_if_rdy_out = can_push;

  always_comb begin
    push_n = '0;
    if (can_push) push_n = if_instqueue_cnt_in;
  end

  always_comb begin
    pop_n = '0;
    if (!stall_in) pop_n = (count > CNW'(OUT_W)) ? CNW'(OUT_W) : count;
  end

  assign count_nxt = count + CNW'(push_n) - pop_n;

  // Storage is not reset: slots are only read after being written.
  always_ff @(posedge clk_in) begin
    if (rdy_in && !flush) begin
      for (int i = 0; i < int'(IN_W); i++) begin
        if (i < int'(push_n)) begin
          mem_inst[tail + PW'(i)] <= fetch_inst[i];
          mem_pc[tail + PW'(i)]   <= fetch_pc[i];
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        head  <= head + PW'(pop_n);
        tail  <= tail + PW'(push_n);
        count <= count_nxt;
      end
    end
  end

  // Issue registers: lanes beyond the pop width keep whatever they held.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      en_q   <= '0;
      inst_q <= '0;
      pc_q   <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        en_q <= '0;
      end else begin
        for (int k = 0; k < int'(OUT_W); k++) begin
          en_q[k] <= (k < int'(pop_n));
          if (k < int'(pop_n)) begin
            inst_q[k] <= mem_inst[head + PW'(k)];
            pc_q[k]   <= mem_pc[head + PW'(k)];
          end
        end
      end
    end
  end

  assign instqueue_decoder_en_out   = en_q;
  assign instqueue_decoder_inst_out = inst_q;
  assign instqueue_decoder_pc_out   = pc_q;
  assign instqueue_count_out        = count;

endmodule

// File: tb/tb_instqueue_mw.sv
// Randomised bench for instqueue_mw against a queue-based reference model, plus directed literal checks.
module tb_instqueue_mw;
  localparam int DEPTH = 8;
  localparam int IN_W  = 2;
  localparam int OUT_W = 2;
  localparam int IDW   = 32;
  localparam int AW    = 32;
  localparam int CIW   = $clog2(IN_W + 1);
  localparam int CNW   = $clog2(DEPTH + 1);

  logic clk_in = 1'b0;
  logic rst_n_in;
  logic rdy_in, stall_in;
  logic [CIW-1:0] cnt_in;
  logic [IN_W-1:0][IDW-1:0] f_inst;
  logic [IN_W-1:0][AW-1:0]  f_pc;
  logic rob_rst, dec_rst, bp_rst;
  logic if_rdy;
  logic [OUT_W-1:0] en_out;
  logic [OUT_W*IDW-1:0] inst_out;
  logic [OUT_W*AW-1:0]  pc_out;
  logic [CNW-1:0] count_out;

  always #5 clk_in = ~clk_in;

  instqueue_mw #(.DEPTH(DEPTH), .IN_W(IN_W), .OUT_W(OUT_W), .IDW(IDW), .AW(AW)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .stall_in(stall_in),
    .if_instqueue_cnt_in(cnt_in), .if_instqueue_inst_in(f_inst), .if_instqueue_pc_in(f_pc),
    .instqueue_if_rdy_out(if_rdy),
    .rob_instqueue_rst_in(rob_rst), .decoder_instqueue_rst_in(dec_rst), .bp_instqueue_rst_in(bp_rst),
    .instqueue_decoder_en_out(en_out), .instqueue_decoder_inst_out(inst_out),
    .instqueue_decoder_pc_out(pc_out), .instqueue_count_out(count_out)
  );

  typedef struct packed { logic [AW-1:0] pc; logic [IDW-1:0] inst; } entry_t;

  // Reference model: the queue contents in program order plus the last issued lanes.
  entry_t q[$];
  logic [OUT_W-1:0] m_en;
  logic [AW-1:0]  m_pc   [OUT_W];
  logic [IDW-1:0] m_inst [OUT_W];
  bit             m_known[OUT_W];

  int checks = 0;
  int errors = 0;
  logic [AW-1:0] next_pc = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_en = '0;
    for (int k = 0; k < OUT_W; k++) begin
      m_pc[k] = '0; m_inst[k] = '0; m_known[k] = 1'b1;
    end
  endtask

  task automatic model_step();
    int sz, n;
    entry_t e;
    if (!rdy_in) return;
    if (rob_rst || dec_rst || bp_rst) begin
      q.delete();
      m_en = '0;
      return;
    end
    sz = q.size();
    n = stall_in ? 0 : ((sz < OUT_W) ? sz : OUT_W);
    for (int k = 0; k < OUT_W; k++) begin
      m_en[k] = (k < n);
      if (k < n) begin
        e = q.pop_front();
        m_pc[k] = e.pc; m_inst[k] = e.inst; m_known[k] = 1'b1;
      end else if (n > 0) begin
        m_known[k] = 1'b0;
      end
    end
    if ((DEPTH - sz) >= IN_W) begin
      for (int i = 0; i < IN_W; i++)
        if (i < int'(cnt_in)) q.push_back({f_pc[i], f_inst[i]});
    end
  endtask

  // Single compare process: DUT outputs against the model every cycle.
  always @(negedge clk_in) begin
    chk("count", 64'(count_out), 64'(q.size()));
    chk("rdy_out", 64'(if_rdy), 64'((DEPTH - q.size()) >= IN_W));
    chk("en_out", 64'(en_out), 64'(m_en));
    for (int k = 0; k < OUT_W; k++) begin
      if (m_known[k]) begin
        chk($sformatf("pc_lane%0d", k), 64'(pc_out[k*AW +: AW]), 64'(m_pc[k]));
        chk($sformatf("inst_lane%0d", k), 64'(inst_out[k*IDW +: IDW]), 64'(m_inst[k]));
      end
    end
  end

  always @(posedge clk_in) begin
    if (rst_n_in) assert (cnt_in <= IN_W) else $error("illegal fetch lane count %0d", cnt_in);
  end

  // One clock: drive inputs, advance the model at the edge, return just after the next falling edge.
  task automatic cycle(input int c, input bit st, input bit rdy = 1'b1,
                       input bit frob = 1'b0, input bit fdec = 1'b0, input bit fbp = 1'b0);
    cnt_in = CIW'(c);
    stall_in = st; rdy_in = rdy;
    rob_rst = frob; dec_rst = fdec; bp_rst = fbp;
    for (int i = 0; i < IN_W; i++) begin
      if (i < c) begin
        f_pc[i] = next_pc; next_pc += 4;
        f_inst[i] = $urandom;
      end else begin
        f_pc[i] = $urandom; f_inst[i] = $urandom;
      end
    end
    @(posedge clk_in);
    model_step();
    @(negedge clk_in);
    #1;
  endtask

  function automatic logic [AW-1:0] lane_pc(input int k);
    return pc_out[k*AW +: AW];
  endfunction

  initial begin
    rst_n_in = 1'b0; rdy_in = 1'b1; stall_in = 1'b1; cnt_in = '0;
    f_inst = '0; f_pc = '0; rob_rst = 1'b0; dec_rst = 1'b0; bp_rst = 1'b0;
    model_reset();
    #12;
    chk("reset_en", 64'(en_out), 64'd0);
    chk("reset_count", 64'(count_out), 64'd0);
    chk("reset_rdy", 64'(if_rdy), 64'd1);
    chk("reset_pc", 64'(pc_out), 64'd0);
    rst_n_in = 1'b1;

    // Fill with decode stalled.
    next_pc = 32'h0;
    for (int b = 0; b < 4; b++) begin
      cycle(2, 1'b1);
      chk("fill_count", 64'(count_out), 64'(2 * (b + 1)));
    end
    chk("fill_rdy_low", 64'(if_rdy), 64'd0);
    cycle(2, 1'b1);
    chk("full_push_ignored", 64'(count_out), 64'd8);

    // Drain two per cycle.
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1'b0);
      chk("drain_en", 64'(en_out), 64'b11);
      chk("drain_pc0", 64'(lane_pc(0)), 64'(8 * i));
      chk("drain_pc1", 64'(lane_pc(1)), 64'(8 * i + 4));
      chk("drain_count", 64'(count_out), 64'(6 - 2 * i));
    end
    cycle(0, 1'b0);
    chk("drained_en", 64'(en_out), 64'd0);
    chk("drained_count", 64'(count_out), 64'd0);

    // Odd occupancy.
    next_pc = 32'h40;
    cycle(1, 1'b1);
    cycle(0, 1'b0);
    chk("odd_en", 64'(en_out), 64'b01);
    chk("odd_pc0", 64'(lane_pc(0)), 64'h40);

    // Sustained push+pop with pointer wrap.
    next_pc = 32'h100;
    cycle(2, 1'b0);
    for (int j = 1; j <= 20; j++) begin
      cycle(2, 1'b0);
      chk("wrap_count", 64'(count_out), 64'd2);
      chk("wrap_en", 64'(en_out), 64'b11);
      chk("wrap_pc0", 64'(lane_pc(0)), 64'(32'h100 + 8 * (j - 1)));
      chk("wrap_pc1", 64'(lane_pc(1)), 64'(32'h104 + 8 * (j - 1)));
    end
    cycle(0, 1'b0);
    cycle(0, 1'b0);
    chk("wrap_empty", 64'(count_out), 64'd0);

    // Flush colliding with push and pop.
    next_pc = 32'h200;
    for (int b = 0; b < 3; b++) cycle(2, 1'b1);
    chk("pre_flush_count", 64'(count_out), 64'd6);
    cycle(2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("flush_count", 64'(count_out), 64'd0);
    chk("flush_en", 64'(en_out), 64'd0);
    cycle(0, 1'b0);
    chk("flush_dropped_en", 64'(en_out), 64'd0);
    chk("flush_dropped_count", 64'(count_out), 64'd0);
    for (int b = 0; b < 3; b++) cycle(2, 1'b1);
    cycle(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("frozen_count", 64'(count_out), 64'd6);
    chk("frozen_en", 64'(en_out), 64'd0);
    cycle(0, 1'b0);
    chk("after_freeze_en", 64'(en_out), 64'b11);
    chk("after_freeze_pc0", 64'(lane_pc(0)), 64'h220);

    // Asynchronous reset with five entries queued.
    cycle(1, 1'b1);
    chk("pre_reset_count", 64'(count_out), 64'd5);
    cnt_in = '0;
    rst_n_in = 1'b0;
    model_reset();
    #1;
    chk("async_reset_en", 64'(en_out), 64'd0);
    chk("async_reset_count", 64'(count_out), 64'd0);
    rst_n_in = 1'b1;
    #1;
    chk("post_reset_rdy", 64'(if_rdy), 64'd1);
    cycle(0, 1'b1);

    // Random traffic.
    for (int t = 0; t < 3000; t++) begin
      cycle($urandom_range(0, IN_W), ($urandom_range(0, 99) < 30),
            ($urandom_range(0, 99) < 90),
            ($urandom_range(0, 199) < 3), ($urandom_range(0, 199) < 3),
            ($urandom_range(0, 199) < 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
